// File: rtl/pixel_compose.sv
// pixel_compose: final pixel stage of the LCD datapath.
// Merges sprite draw flags into one RGB565 value with fixed layer priority
// over a 2-stage pipeline, and runs the game life-cycle FSM
// (IDLE -> RUN -> FLASH -> DEAD -> RUN) driven by dino/obstacle overlap.
module pixel_compose #(
   parameter logic [10:0] H_ACTIVE     = 11'd800,
   parameter logic [10:0] V_ACTIVE     = 11'd480,
   parameter logic [15:0] COLOR_BG     = 16'hFFFF,
   parameter logic [15:0] COLOR_FG     = 16'h5AEB,
   parameter logic [15:0] COLOR_CLOUD  = 16'hC618,
   parameter logic [5:0]  FLASH_FRAMES = 6'd16
) (
   input  logic        lcd_pclk,
   input  logic        rst,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   input  logic        dino_draw,
   input  logic        cactus_draw,
   input  logic        ground_draw,
   input  logic        cloud_draw,
   input  logic        restart,
   output logic [15:0] pixel_data,
   output logic        is_living,
   output logic        hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLASH = 2'd2,
      DEAD  = 2'd3
   } state_t;

   state_t      state;
   logic [5:0]  flash_cnt;

   // Stage-1 registers
   logic        s1_dino;
   logic        s1_cactus;
   logic        s1_ground;
   logic        s1_cloud;
   logic        s1_active;
   logic        s1_tick;

   logic [15:0] base_color;
   logic        invert;
   logic [15:0] pixel_next;
   logic        coll;

   // Stage 1: capture draw flags plus active-area and frame-start decodes
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         s1_dino   <= 1'b0;
         s1_cactus <= 1'b0;
         s1_ground <= 1'b0;
         s1_cloud  <= 1'b0;
         s1_active <= 1'b0;
         s1_tick   <= 1'b0;
      end else begin
         s1_dino   <= dino_draw;
         s1_cactus <= cactus_draw;
         s1_ground <= ground_draw;
         s1_cloud  <= cloud_draw;
         s1_active <= (pixel_xpos < H_ACTIVE) && (pixel_ypos < V_ACTIVE);
         s1_tick   <= (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
      end
   end

   // Layer priority dino > cactus > ground > cloud, inversion on odd flash frames
   always_comb begin
      base_color = COLOR_BG;
      if (s1_dino || s1_cactus || s1_ground) begin
         base_color = COLOR_FG;
      end else if (s1_cloud) begin
         base_color = COLOR_CLOUD;
      end
      invert     = (state == FLASH) && flash_cnt[0];
      pixel_next = 16'h0000;
      if (s1_active) begin
         pixel_next = invert ? ~base_color : base_color;
      end
   end

   // Overlap only counts inside the visible area
   assign coll = s1_dino && s1_cactus && s1_active;

   // Stage 2: registered pixel output
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         pixel_data <= 16'h0000;
      end else begin
         pixel_data <= pixel_next;
      end
   end

   // Life-cycle FSM; is_living is the registered decode of next state == RUN
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         state     <= IDLE;
         flash_cnt <= 6'd0;
         hit       <= 1'b0;
         is_living <= 1'b0;
      end else begin
         is_living <= 1'b0;
         case (state)
            IDLE: begin
               if (restart) begin
                  state     <= RUN;
                  is_living <= 1'b1;
               end
            end
            RUN: begin
               // restart has no effect while running
               if (coll) begin
                  state     <= FLASH;
                  hit       <= 1'b1;
                  flash_cnt <= 6'd0;
               end else begin
                  is_living <= 1'b1;
               end
            end
            FLASH: begin
               // restart and further overlaps are ignored while flashing
               if (s1_tick) begin
                  flash_cnt <= flash_cnt + 6'd1;
                  if (flash_cnt == FLASH_FRAMES - 6'd1) begin
                     state <= DEAD;
                  end
               end
            end
            DEAD: begin
               if (restart) begin
                  state     <= RUN;
                  hit       <= 1'b0;
                  is_living <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_compose.sv
// Testbench for pixel_compose: directed vectors, expected responses queued
// with their due cycle and checked by an independent monitor process.
module tb_pixel_compose;

  localparam logic [15:0] C_BG   = 16'hFFFF;
  localparam logic [15:0] C_FG   = 16'h5AEB;
  localparam logic [15:0] C_CL   = 16'hC618;
  localparam logic [15:0] C_FGI  = 16'hA514;   // ~5AEB
  localparam logic [15:0] C_CLI  = 16'h39E7;   // ~C618
  localparam logic [15:0] C_OFF  = 16'h0000;

  // flag order {dino, cactus, ground, cloud}
  localparam logic [3:0] F_DINO = 4'b1000;
  localparam logic [3:0] F_CAC  = 4'b0100;
  localparam logic [3:0] F_GND  = 4'b0010;
  localparam logic [3:0] F_CLD  = 4'b0001;

  localparam int K_PIX = 0;
  localparam int K_LIV = 1;
  localparam int K_HIT = 2;

  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        dino_draw;
  logic        cactus_draw;
  logic        ground_draw;
  logic        cloud_draw;
  logic        restart;
  logic [15:0] pixel_data;
  logic        is_living;
  logic        hit;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  pixel_compose dut (
    .lcd_pclk    (lcd_pclk),
    .rst         (rst),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .dino_draw   (dino_draw),
    .cactus_draw (cactus_draw),
    .ground_draw (ground_draw),
    .cloud_draw  (cloud_draw),
    .restart     (restart),
    .pixel_data  (pixel_data),
    .is_living   (is_living),
    .hit         (hit)
  );

  // clock
  always #5 lcd_pclk = ~lcd_pclk;

  // monitor: after each edge, compare every expectation that falls due now
  initial begin
    forever begin
      @(posedge lcd_pclk);
      #1;
      cyc++;
      begin
        int i;
        logic [15:0] act;
        i = 0;
        while (i < exp_q.size()) begin
          if (exp_q[i].due == cyc) begin
            case (exp_q[i].kind)
              K_PIX:   act = pixel_data;
              K_LIV:   act = {15'd0, is_living};
              default: act = {15'd0, hit};
            endcase
            n_checks++;
            if (act == exp_q[i].val) begin
              n_pass++;
            end else begin
              $display("FAIL %s @cyc %0d: got %h expected %h",
                       exp_q[i].name, cyc, act, exp_q[i].val);
            end
            exp_q.delete(i);
          end else begin
            i++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic [10:0] x, input logic [10:0] y,
                        input logic [3:0] f, input logic rs, input logic rt);
    pixel_xpos = x;
    pixel_ypos = y;
    {dino_draw, cactus_draw, ground_draw, cloud_draw} = f;
    restart = rs;
    rst     = rt;
  endtask

  task automatic expect_v(input int kind, input int lat, input logic [15:0] v,
                          input string nm);
    exp_t e;
    e.due  = cyc + lat;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge lcd_pclk);
  endtask

  // directed priority vectors (inputs while RUN, expected colour two edges later)
  logic [10:0] pv_x   [8] = '{11'd10, 11'd10, 11'd10, 11'd800, 11'd10, 11'd10, 11'd799, 11'd10};
  logic [10:0] pv_y   [8] = '{11'd10, 11'd10, 11'd10, 11'd10, 11'd10, 11'd10, 11'd479, 11'd480};
  logic [3:0]  pv_f   [8] = '{4'b0011, 4'b0001, 4'b0000, 4'b1111, 4'b1011, 4'b0101, 4'b0001, 4'b0001};
  logic [15:0] pv_exp [8] = '{16'h5AEB, 16'hC618, 16'hFFFF, 16'h0000, 16'h5AEB, 16'h5AEB, 16'hC618, 16'h0000};

  initial begin
    logic [5:0]  m;
    logic [15:0] base;
    logic [15:0] want;

    // reset with random inputs
    for (int r = 0; r < 3; r++) begin
      set_in(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      if (r == 2) begin
        expect_v(K_PIX, 1, C_OFF, "reset_pixel");
        expect_v(K_LIV, 1, 16'd0, "reset_living");
        expect_v(K_HIT, 1, 16'd0, "reset_hit");
      end
      step();
    end

    n_checks++;
    if (pixel_data == C_OFF) n_pass++;
    else $display("FAIL direct_reset_pixel: got %h", pixel_data);
    n_checks++;
    if (is_living == 1'b0) n_pass++;
    else $display("FAIL direct_reset_living: got %b", is_living);
    n_checks++;
    if (hit == 1'b0) n_pass++;
    else $display("FAIL direct_reset_hit: got %b", hit);

    // idle without restart stays not-living, normal palette
    for (int r = 0; r < 4; r++) begin
      set_in(11'd10, 11'd10, F_CLD, 1'b0, 1'b0);
      expect_v(K_LIV, 1, 16'd0, "idle_living");
      expect_v(K_PIX, 2, C_CL, "idle_pixel");
      step();
    end

    // restart from IDLE
    set_in(11'd10, 11'd10, 4'b0000, 1'b1, 1'b0);
    expect_v(K_LIV, 1, 16'd1, "restart_living");
    expect_v(K_HIT, 1, 16'd0, "restart_hit");
    expect_v(K_PIX, 2, C_BG, "restart_pixel");
    step();

    n_checks++;
    if (is_living == 1'b1) n_pass++;
    else $display("FAIL direct_restart_living: got %b", is_living);

    // layer priority and active-area masking
    for (int k = 0; k < 8; k++) begin
      set_in(pv_x[k], pv_y[k], pv_f[k], 1'b0, 1'b0);
      expect_v(K_LIV, 1, 16'd1, $sformatf("prio_living_%0d", k));
      expect_v(K_PIX, 2, pv_exp[k], $sformatf("prio_pixel_%0d", k));
      step();
    end

    // collision at (100,300)
    set_in(11'd100, 11'd300, F_DINO | F_CAC, 1'b0, 1'b0);
    expect_v(K_LIV, 1, 16'd1, "coll_living_n");
    expect_v(K_LIV, 2, 16'd0, "coll_living_n1");
    expect_v(K_HIT, 2, 16'd1, "coll_hit_n1");
    expect_v(K_PIX, 2, C_FG, "coll_pixel");
    step();
    set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_BG, "flash0_pixel");
    step();

    // 16 flash frames, restart at tick 5 and overlap at frame 3 ignored
    m = 6'd0;
    for (int i = 1; i <= 16; i++) begin
      set_in(11'd0, 11'd0, 4'b0000, (i == 5), 1'b0);
      want = m[0] ? C_OFF : C_BG;
      expect_v(K_PIX, 2, want, $sformatf("flash_tick_pixel_%0d", i));
      expect_v(K_LIV, 1, 16'd0, $sformatf("flash_living_%0d", i));
      expect_v(K_HIT, 1, 16'd1, $sformatf("flash_hit_%0d", i));
      step();
      m = m + 6'd1;
      set_in(11'd10, 11'd10, (i == 3) ? (F_DINO | F_CAC) : F_CLD, 1'b0, 1'b0);
      base = (i == 3) ? C_FG : C_CL;
      if (i == 16) want = base;
      else if (m[0]) want = (i == 3) ? C_FGI : C_CLI;
      else want = base;
      expect_v(K_PIX, 2, want, $sformatf("flash_mid_pixel_%0d", i));
      step();
    end

    // DEAD: normal palette, hit held, not living
    set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_BG, "dead_pixel");
    expect_v(K_LIV, 1, 16'd0, "dead_living");
    expect_v(K_HIT, 1, 16'd1, "dead_hit");
    step();

    n_checks++;
    if (hit == 1'b1) n_pass++;
    else $display("FAIL direct_dead_hit: got %b", hit);
    n_checks++;
    if (is_living == 1'b0) n_pass++;
    else $display("FAIL direct_dead_living: got %b", is_living);

    set_in(11'd0, 11'd0, F_CLD, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_CL, "dead_tick_pixel");
    step();
    set_in(11'd10, 11'd10, F_CLD, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_CL, "dead_next_frame_pixel");
    step();

    // restart from DEAD
    set_in(11'd10, 11'd10, 4'b0000, 1'b1, 1'b0);
    expect_v(K_LIV, 1, 16'd1, "dead_restart_living");
    expect_v(K_HIT, 1, 16'd0, "dead_restart_hit");
    expect_v(K_PIX, 2, C_BG, "dead_restart_pixel");
    step();

    n_checks++;
    if (is_living == 1'b1) n_pass++;
    else $display("FAIL direct_dead_restart_living: got %b", is_living);
    n_checks++;
    if (hit == 1'b0) n_pass++;
    else $display("FAIL direct_dead_restart_hit: got %b", hit);

    // second hit, then reset at flash frame 5
    set_in(11'd200, 11'd200, F_DINO | F_CAC, 1'b0, 1'b0);
    expect_v(K_LIV, 2, 16'd0, "coll2_living");
    expect_v(K_HIT, 2, 16'd1, "coll2_hit");
    expect_v(K_PIX, 2, C_FG, "coll2_pixel");
    step();
    m = 6'd0;
    for (int i = 1; i <= 5; i++) begin
      set_in(11'd0, 11'd0, 4'b0000, 1'b0, 1'b0);
      expect_v(K_PIX, 2, m[0] ? C_OFF : C_BG, $sformatf("flash2_tick_pixel_%0d", i));
      step();
      m = m + 6'd1;
      set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
      expect_v(K_PIX, 2, m[0] ? C_OFF : C_BG, $sformatf("flash2_mid_pixel_%0d", i));
      step();
    end
    set_in(11'd10, 11'd10, F_CLD, 1'b0, 1'b0);
    step();
    set_in(11'd10, 11'd10, F_CLD, 1'b1, 1'b1);
    expect_v(K_PIX, 1, C_OFF, "midrst_pixel");
    expect_v(K_PIX, 2, C_OFF, "midrst_pipe_pixel");
    expect_v(K_LIV, 1, 16'd0, "midrst_living");
    expect_v(K_HIT, 1, 16'd0, "midrst_hit");
    step();
    set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
    expect_v(K_LIV, 1, 16'd0, "midrst_idle_living");
    expect_v(K_PIX, 2, C_BG, "midrst_idle_pixel");
    step();
    set_in(11'd10, 11'd10, F_CLD, 1'b1, 1'b0);
    expect_v(K_LIV, 1, 16'd1, "midrst_restart_living");
    expect_v(K_HIT, 1, 16'd0, "midrst_restart_hit");
    expect_v(K_PIX, 2, C_CL, "midrst_restart_pixel");
    step();

    // third hit: first flash frame inverts again
    set_in(11'd300, 11'd100, F_DINO | F_CAC, 1'b0, 1'b0);
    expect_v(K_HIT, 2, 16'd1, "coll3_hit");
    step();
    set_in(11'd0, 11'd0, 4'b0000, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_BG, "flash3_tick_pixel");
    step();
    set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
    expect_v(K_PIX, 2, C_OFF, "flash3_frame1_pixel");
    step();

    // drain
    set_in(11'd10, 11'd10, 4'b0000, 1'b0, 1'b0);
    repeat (4) step();
    while (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s: got never-checked expected %h", exp_q[0].name, exp_q[0].val);
      exp_q.delete(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_compose.md
# pixel_compose

Final pixel stage of the LCD datapath: merges the per-pixel draw flags from the sprite generators (dino, cactus, ground, cloud) into one RGB565 value with fixed layer priority, on a 2-stage pipeline. Also owns the game life-cycle state machine. It detects dino/obstacle pixel overlap, drives `is_living` back to the sprite movers (cloud, cactus, ground), and flashes the screen for a fixed number of frames on a hit.

## Interface
Parameters:
- `H_ACTIVE`, 800: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `COLOR_BG`, 16'hFFFF: background colour.
- `COLOR_FG`, 16'h5AEB: dino, cactus and ground colour.
- `COLOR_CLOUD`, 16'hC618: cloud colour.
- `FLASH_FRAMES`, 6'd16: number of frames spent in the hit-flash state.

Ports:
- `lcd_pclk`, in, 1: pixel clock. The only clock in the block.
- `rst`, in, 1: reset. Synchronous and active-high.
- `pixel_xpos`, in, 11: current pixel column.
- `pixel_ypos`, in, 11: current pixel row.
- `dino_draw`, in, 1: dino covers this pixel.
- `cactus_draw`, in, 1: obstacle covers this pixel.
- `ground_draw`, in, 1: ground covers this pixel.
- `cloud_draw`, in, 1: cloud covers this pixel.
- `restart`, in, 1: single-cycle start/restart request.
- `pixel_data`, out, 16: RGB565 value, registered.
- `is_living`, out, 1: high only in the RUN state, registered.
- `hit`, out, 1: sticky collision flag, registered.

## Operation
- Stage 1 registers the following on every `lcd_pclk`:
  - the four draw flags;
  - `active` = (`pixel_xpos` < H_ACTIVE) && (`pixel_ypos` < V_ACTIVE);
  - `frame_tick` = (`pixel_xpos` == 0) && (`pixel_ypos` == 0).
- Stage 2 computes `pixel_data` from the stage-1 registers:
  - if not `active`: 16'h0000;
  - otherwise the first match in priority order dino > cactus > ground > cloud, with COLOR_FG for dino, cactus and ground, COLOR_CLOUD for cloud, and COLOR_BG when no flag is set.
- Flash inversion: in FLASH, when `flash_cnt[0]` == 1, active pixels output the bitwise complement of the selected colour. Inactive pixels stay 16'h0000.
- Collision: `coll` = stage-1 dino && stage-1 cactus && stage-1 `active`. It is evaluated only in RUN.
- FSM states: IDLE, RUN, FLASH, DEAD. Reset state is IDLE.
  - IDLE: `restart` → RUN.
  - RUN: `coll` → FLASH; also sets `hit`=1 and `flash_cnt`=0. `restart` is ignored.
  - FLASH: each stage-1 `frame_tick` increments `flash_cnt` (6 bits). On the tick where `flash_cnt` == FLASH_FRAMES-1, go to DEAD. `restart` and `coll` are ignored.
  - DEAD: shows the normal palette with no inversion. `restart` → RUN and clears `hit`.
- `is_living` is a registered decode of next-state == RUN. It is high in the same cycle the state register shows RUN.
- `restart` and `coll` in the same cycle: the current state decides which one acts. The other is ignored, and no event is queued.
- Asserting `rst` in any state, mid-frame or mid-flash, returns the block to IDLE on the next edge. Counters and pipeline registers clear.

## Timing
- Reset values: `pixel_data`=0, `is_living`=0, `hit`=0, state=IDLE, `flash_cnt`=0, all stage-1 registers 0.
- Pixel latency: inputs sampled at edge N produce `pixel_data` after edge N+1 (2-cycle latency). Upstream coordinate and sync timing must be delayed by 2 cycles to match.
- Collision latency:
  - overlap presented at edge N is registered into stage 1 at N;
  - the state changes to FLASH and `is_living` falls at N+1;
  - `hit` rises at N+1.
- `restart` sampled at edge N in IDLE or DEAD: `is_living`=1 after edge N.
- Flash duration: exactly FLASH_FRAMES stage-1 `frame_tick` pulses after entry, then DEAD. A partial first frame counts as one frame only at its next tick.
- `flash_cnt` wraps at 64. This is never reached when FLASH_FRAMES ≤ 63.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs. Then `pixel_data`=0, `is_living`=0, `hit`=0, and `restart`-free cycles keep `is_living`=0.
- Priority: at x=10, y=10 in RUN, drive cloud+ground → 16'h5AEB two cycles later. Drive cloud only → 16'hC618. Drive no flags → 16'hFFFF. At x=800, y=10 with all flags set → 16'h0000.
- Collision: in RUN, pulse dino&&cactus at x=100, y=300 for 1 cycle at edge N. `is_living`=0 and `hit`=1 after edge N+1. A pixel at frame 1 of the flash reads 16'h0000 where the normal colour would be 16'hFFFF.
- Flash length: after the hit, run 16 frame ticks. State becomes DEAD on the 16th tick, and inversion stops on the next frame.
- Ignored restart: pulse `restart` during FLASH. There is no change and `hit` stays 1. Pulse `restart` in DEAD: `is_living`=1 and `hit`=0 after that edge.
- Mid-operation reset: assert `rst` during FLASH at flash frame 5. Result is IDLE, `hit`=0 and `flash_cnt`=0. A following `restart` enters RUN cleanly.
